// File: rtl/hdmi_timing_gen.sv
// Raster timing generator for the HDMI output path: free-running h/v counters,
// zero-latency blank/frame flags for the line-buffer FIFO, and a one-stage registered video output.
module hdmi_timing_gen #(
   parameter int H_ACTIVE = 1280,
   parameter int H_FP     = 110,
   parameter int H_SYNC   = 40,
   parameter int H_BP     = 220,
   parameter int V_ACTIVE = 720,
   parameter int V_FP     = 5,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 20,
   parameter bit SYNC_POL = 1'b1
) (
   input  logic        hdmi_clk,
   input  logic        hdmi_reset_n,
   input  logic [23:0] hdmi_pix,
   input  logic        hdmi_pix_vld,
   output logic        hdmi_frame,
   output logic        hdmi_blank,
   output logic [23:0] vid_pix,
   output logic        vid_de,
   output logic        vid_hsync,
   output logic        vid_vsync,
   output logic [15:0] underrun_cnt
);

   localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW           = $clog2(H_TOTAL);
   localparam int VW           = $clog2(V_TOTAL);
   localparam int H_SYNC_START = H_ACTIVE + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int V_SYNC_START = V_ACTIVE + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

   typedef enum logic {
      ST_RESET,
      ST_RUN
   } state_t;

   state_t        state_q;
   logic [HW-1:0] h_cnt_q, h_cnt_d;
   logic [VW-1:0] v_cnt_q, v_cnt_d;
   logic [23:0]   vid_pix_q, vid_pix_d;
   logic          vid_de_q, vid_de_d;
   logic          vid_hsync_q, vid_hsync_d;
   logic          vid_vsync_q, vid_vsync_d;
   logic [15:0]   underrun_q, underrun_d;
   logic          active;
   logic          in_hsync;
   logic          in_vsync;

   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      // Pixel (0,0) is presented during the release cycle itself, so leaving RESET resumes at pixel 1.
      unique case (state_q)
         ST_RUN: begin
            if (h_cnt_q == H_LAST) begin
               h_cnt_d = '0;
               v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
            end else begin
               h_cnt_d = h_cnt_q + HW'(1);
            end
         end
         default: begin
            h_cnt_d = HW'(1);
            v_cnt_d = '0;
         end
      endcase

      active     = hdmi_reset_n && (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
      hdmi_blank = ~active;
      hdmi_frame = hdmi_reset_n && (int'(v_cnt_q) < V_ACTIVE);
      in_hsync   = (int'(h_cnt_q) >= H_SYNC_START) && (int'(h_cnt_q) < H_SYNC_END);
      in_vsync   = (int'(v_cnt_q) >= V_SYNC_START) && (int'(v_cnt_q) < V_SYNC_END);

      vid_de_d    = active;
      vid_hsync_d = in_hsync ? SYNC_POL : ~SYNC_POL;
      vid_vsync_d = in_vsync ? SYNC_POL : ~SYNC_POL;
      vid_pix_d   = (active && hdmi_pix_vld) ? hdmi_pix : 24'h000000;

      underrun_d = underrun_q;
      if (active && !hdmi_pix_vld && (underrun_q != 16'hFFFF)) begin
         underrun_d = underrun_q + 16'd1;
      end
   end

   always_ff @(posedge hdmi_clk) begin
      if (!hdmi_reset_n) begin
         state_q     <= ST_RESET;
         h_cnt_q     <= '0;
         v_cnt_q     <= '0;
         vid_de_q    <= 1'b0;
         vid_pix_q   <= 24'h000000;
         vid_hsync_q <= ~SYNC_POL;
         vid_vsync_q <= ~SYNC_POL;
         underrun_q  <= 16'h0000;
      end else begin
         state_q     <= ST_RUN;
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         vid_de_q    <= vid_de_d;
         vid_pix_q   <= vid_pix_d;
         vid_hsync_q <= vid_hsync_d;
         vid_vsync_q <= vid_vsync_d;
         underrun_q  <= underrun_d;
      end
   end

   assign vid_pix      = vid_pix_q;
   assign vid_de       = vid_de_q;
   assign vid_hsync    = vid_hsync_q;
   assign vid_vsync    = vid_vsync_q;
   assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Bench for hdmi_timing_gen: a tiny 14x7 raster checked cycle-by-cycle against a bench-side
// raster model, plus a wide-active instance used to drive the underrun counter into saturation.
module tb_hdmi_timing_gen;

   logic        clk = 1'b0;
   logic        resetN;
   logic [23:0] hdmiPix;
   logic        hdmiPixVld;
   logic        hdmiFrame;
   logic        hdmiBlank;
   logic [23:0] vidPix;
   logic        vidDe;
   logic        vidHsync;
   logic        vidVsync;
   logic [15:0] underrunCnt;

   logic        satResetN;
   logic [23:0] satPix;
   logic        satPixVld;
   logic        satFrame;
   logic        satBlank;
   logic [23:0] satVidPix;
   logic        satDe;
   logic        satHsync;
   logic        satVsync;
   logic [15:0] satUnderrun;

   int checkCount = 0;
   int errorCount = 0;

   int          hRef, vRef, underRef;
   logic        prevActive, prevVld, prevHs, prevVs, prevObsHs, prevObsVs;
   logic [23:0] prevPix, pixCounter;
   int          cycleIdx, deSeen, lastHsRise, lastVsRise, hsPeriod, vsPeriod;

   always #5 clk = ~clk;

   hdmi_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .SYNC_POL(1'b1)
   ) dut (
      .hdmi_clk(clk),
      .hdmi_reset_n(resetN),
      .hdmi_pix(hdmiPix),
      .hdmi_pix_vld(hdmiPixVld),
      .hdmi_frame(hdmiFrame),
      .hdmi_blank(hdmiBlank),
      .vid_pix(vidPix),
      .vid_de(vidDe),
      .vid_hsync(vidHsync),
      .vid_vsync(vidVsync),
      .underrun_cnt(underrunCnt)
   );

   hdmi_timing_gen #(
      .H_ACTIVE(200), .H_FP(1), .H_SYNC(1), .H_BP(1),
      .V_ACTIVE(100), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .SYNC_POL(1'b1)
   ) satDut (
      .hdmi_clk(clk),
      .hdmi_reset_n(satResetN),
      .hdmi_pix(satPix),
      .hdmi_pix_vld(satPixVld),
      .hdmi_frame(satFrame),
      .hdmi_blank(satBlank),
      .vid_pix(satVidPix),
      .vid_de(satDe),
      .vid_hsync(satHsync),
      .vid_vsync(satVsync),
      .underrun_cnt(satUnderrun)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Restart the raster model at (0,0) for the cycle that follows a reset release.
   task automatic resetModel();
      hRef       = 0;
      vRef       = 0;
      underRef   = 0;
      prevActive = 1'b0;
      prevVld    = 1'b0;
      prevHs     = 1'b0;
      prevVs     = 1'b0;
      prevPix    = 24'h0;
      prevObsHs  = 1'b0;
      prevObsVs  = 1'b0;
      deSeen     = 0;
      lastHsRise = -1;
      lastVsRise = -1;
      hsPeriod   = 0;
      vsPeriod   = 0;
   endtask

   // Entered just after a rising edge; drives one cycle, checks at the falling edge, advances the model.
   // dropMode 1 starves three active pixels on line 1 and also holds vld low through some blanking.
   task automatic applyStimulus(input int nCycles, input int dropMode);
      logic active, vldNow;
      for (int c = 0; c < nCycles; c++) begin
         active = (hRef < 8) && (vRef < 4);
         vldNow = 1'b1;
         if (dropMode == 1 && vRef == 1 && ((hRef >= 2 && hRef <= 4) || (hRef >= 9 && hRef <= 12)))
            vldNow = 1'b0;
         if (dropMode == 1 && vRef == 5)
            vldNow = 1'b0;
         hdmiPix    = pixCounter;
         hdmiPixVld = vldNow;
         @(negedge clk);
         checkOutput("blank", hdmiBlank, !active);
         checkOutput("frame", hdmiFrame, vRef < 4);
         checkOutput("de", vidDe, prevActive);
         checkOutput("hsync", vidHsync, prevHs);
         checkOutput("vsync", vidVsync, prevVs);
         checkOutput("pix", vidPix, (prevActive && prevVld) ? prevPix : 24'h0);
         checkOutput("underrun", underrunCnt, underRef);
         if (vidDe) deSeen++;
         if (vidHsync && !prevObsHs) begin
            if (lastHsRise >= 0) hsPeriod = cycleIdx - lastHsRise;
            lastHsRise = cycleIdx;
         end
         if (vidVsync && !prevObsVs) begin
            if (lastVsRise >= 0) vsPeriod = cycleIdx - lastVsRise;
            lastVsRise = cycleIdx;
         end
         prevObsHs  = vidHsync;
         prevObsVs  = vidVsync;
         prevActive = active;
         prevVld    = vldNow;
         prevPix    = pixCounter;
         prevHs     = (hRef >= 10) && (hRef <= 11);
         prevVs     = (vRef == 5);
         if (active && !vldNow && underRef < 65535) underRef++;
         pixCounter = pixCounter + 24'h010203;
         cycleIdx++;
         hRef++;
         if (hRef == 14) begin
            hRef = 0;
            vRef = (vRef == 6) ? 0 : vRef + 1;
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int hS, vS, underS;
      resetN     = 1'b0;
      satResetN  = 1'b0;
      hdmiPix    = 24'h0;
      hdmiPixVld = 1'b1;
      satPix     = 24'h0;
      satPixVld  = 1'b0;
      pixCounter = 24'h000001;
      cycleIdx   = 0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("rstBlank", hdmiBlank, 1'b1);
      checkOutput("rstFrame", hdmiFrame, 1'b0);
      checkOutput("rstDe", vidDe, 1'b0);
      checkOutput("rstPix", vidPix, 24'h0);
      checkOutput("rstHsync", vidHsync, 1'b0);
      checkOutput("rstVsync", vidVsync, 1'b0);
      checkOutput("rstUnderrun", underrunCnt, 16'h0);
      @(posedge clk);
      #1;

      resetN = 1'b1;
      resetModel();
      applyStimulus(196, 0);
      checkOutput("deTwoFrames", deSeen, 64);
      checkOutput("linePeriod", hsPeriod, 14);
      checkOutput("framePeriod", vsPeriod, 98);

      applyStimulus(98, 1);
      checkOutput("underrun3", underrunCnt, 3);

      applyStimulus(33, 0);
      resetN = 1'b0;
      @(negedge clk);
      checkOutput("pulseBlank", hdmiBlank, 1'b1);
      checkOutput("pulseFrame", hdmiFrame, 1'b0);
      @(posedge clk);
      #1;
      resetN = 1'b1;
      resetModel();
      applyStimulus(98, 0);
      checkOutput("postPulseDe", deSeen, 32);

      // Saturation instance: vld stays low, so every active pixel of the 203x103 raster is an underrun.
      @(posedge clk);
      #1;
      satResetN = 1'b1;
      hS = 0;
      vS = 0;
      underS = 0;
      for (int c = 0; c < 80000 && underS < 66000; c++) begin
         @(negedge clk);
         checkOutput("satCount", satUnderrun, (underS > 65535) ? 65535 : underS);
         if (hS < 200 && vS < 100) underS++;
         hS++;
         if (hS == 203) begin
            hS = 0;
            vS = (vS == 102) ? 0 : vS + 1;
         end
         @(posedge clk);
         #1;
      end
      if (underS < 66000) checkOutput("satTimeout", underS, 66000);
      @(negedge clk);
      checkOutput("satHold", satUnderrun, 16'hFFFF);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/hdmi_timing_gen.md
HDMI_TIMING_GEN -- requirements
Module: hdmi_timing_gen

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 1280, active pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 110, horizontal front-porch clocks.
REQ-003 The block SHALL have parameter H_SYNC, default 40, hsync width in clocks.
REQ-004 The block SHALL have parameter H_BP, default 220, horizontal back-porch clocks.
REQ-005 The block SHALL have parameter V_ACTIVE, default 720, active lines per frame.
REQ-006 The block SHALL have parameter V_FP, default 5, vertical front-porch lines.
REQ-007 The block SHALL have parameter V_SYNC, default 5, vsync width in lines.
REQ-008 The block SHALL have parameter V_BP, default 20, vertical back-porch lines.
REQ-009 The block SHALL have parameter SYNC_POL, default 1, active level of vid_hsync/vid_vsync.
REQ-010 The block SHALL have port hdmi_clk, input, 1, pixel clock; sole clock.
REQ-011 The block SHALL have port hdmi_reset_n, input, 1, synchronous active-low reset; camera-aligned restart.
REQ-012 The block SHALL have port hdmi_pix, input, pix_t (24), pixel from line-buffer FIFO read side.
REQ-013 The block SHALL have port hdmi_pix_vld, input, 1, FIFO read-side valid.
REQ-014 The block SHALL have port hdmi_frame, output, 1, high during active lines.
REQ-015 The block SHALL have port hdmi_blank, output, 1, low only on active pixels; FIFO read-enable is its inverse.
REQ-016 The block SHALL have port vid_pix, output, pix_t (24), pixel to TMDS encoder.
REQ-017 The block SHALL have port vid_de, output, 1, data enable aligned with vid_pix.
REQ-018 The block SHALL have port vid_hsync, output, 1, horizontal sync aligned with vid_pix.
REQ-019 The block SHALL have port vid_vsync, output, 1, vertical sync aligned with vid_pix.
REQ-020 The block SHALL have port underrun_cnt, output, 16, saturating count of starved active pixels.

Function
REQ-021 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H params), then wrap to 0.
REQ-022 v_cnt SHALL advance only on h_cnt wrap, count 0..V_TOTAL-1, then wrap to 0.
REQ-023 Region order SHALL be: active at 0..ACTIVE-1, then FP, then SYNC, then BP, for both axes.
REQ-024 hdmi_blank SHALL be 0 iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; it is combinational from the counters, with zero latency.
REQ-025 hdmi_frame SHALL be 1 iff v_cnt<V_ACTIVE; it is combinational from the counters.
REQ-026 Stage 1 (registered, 1-clock latency) SHALL produce vid_de = ~hdmi_blank.
REQ-027 Stage 1 SHALL produce vid_hsync = SYNC_POL when h_cnt is in the H sync region, else ~SYNC_POL.
REQ-028 Stage 1 SHALL produce vid_vsync = SYNC_POL when v_cnt is in the V sync region (whole lines), else ~SYNC_POL.
REQ-029 Stage 1 vid_pix SHALL be hdmi_pix when ~hdmi_blank and hdmi_pix_vld.
REQ-030 Stage 1 vid_pix SHALL be 24'h000000 when blank, or when active with ~hdmi_vld (underrun).
REQ-031 Each active pixel with hdmi_pix_vld=0 SHALL increment underrun_cnt by 1, holding at 16'hFFFF.
REQ-032 A state machine SHALL run: RESET (hdmi_reset_n=0) -> RUN on first clock with hdmi_reset_n=1; RUN -> RESET on any clock with hdmi_reset_n=0.
REQ-033 Entering RUN SHALL start the timing from h_cnt=0, v_cnt=0, i.e. the first active pixel of line 0.
REQ-034 A reset pulse mid-frame or mid-line SHALL abort the current line immediately, with no completion of porches.
REQ-035 Repeated reset pulses, such as once per camera frame period, SHALL each realign to (0,0).
REQ-036 Counter widths SHALL be clog2(H_TOTAL) and clog2(V_TOTAL); no overflow is permitted at any parameter set.

Reset
REQ-037 While hdmi_reset_n=0: h_cnt=0, v_cnt=0, hdmi_blank=1, hdmi_frame=0.
REQ-038 While hdmi_reset_n=0: vid_de=0, vid_pix=0, vid_hsync=vid_vsync=~SYNC_POL.
REQ-039 underrun_cnt SHALL clear only on hdmi_reset_n=0.
REQ-040 The first clock after release SHALL show hdmi_blank=0 and hdmi_frame=1 (counters at 0,0), with vid_de=1 one clock later.

Verification (small params H 8/2/2/2, V 4/1/1/1, SYNC_POL=1)
REQ-041 Release reset, run 2 frames -> period 14 clocks per line and 98 per frame; hdmi_blank low for 8 clocks on lines 0..3; vid_hsync high at h_cnt 10..11 delayed 1 clock; vid_vsync high for line 5.
REQ-042 hdmi_pix = incrementing counter, vld=1 -> vid_pix equals the value presented one clock earlier on each active clock, and 0 elsewhere; vid_de count = 32 per frame.
REQ-043 Drop hdmi_pix_vld for 3 active clocks -> vid_pix=0 on those 3 aligned clocks and underrun_cnt=3; vld low during blanking -> no increment.
REQ-044 Pulse hdmi_reset_n low 1 clock at h_cnt=5, v_cnt=2 -> next clock h_cnt=0, v_cnt=0, hdmi_frame=1; underrun_cnt=0.
REQ-045 Force 70000 underruns -> underrun_cnt saturates at 16'hFFFF and does not wrap.
REQ-046 Default params, one full frame -> 1650x750 clocks, 921600 vid_de clocks.
